dout_mem_vec: RTL and testbench

DOUT_MEM_VEC -- requirements
Module: dout_mem_vec

---
 rtl/dout_mem_vec.sv | 149 ++++++++++++++
 tb/tb_dout_mem_vec.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dout_mem_vec.sv
// Vector-access element memory with per-lane enables and a ready/valid drain streamer.
// Optional sticky access-error detection is built when DOUT_MEM_ERR_EN is defined.

module dout_mem_vec_lane #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 10000,
  parameter int BASE  = 24,
  parameter int LANE  = 0,
  parameter int IW    = 14
) (
  input  logic [WIDTH-1:0] address,
  input  logic             en,
  output logic             in_rng,
  output logic             act,
  output logic [IW-1:0]    idx
);
  // 64-bit offset so address - BASE + LANE never wraps for any legal WIDTH
  logic [63:0] off;

  assign off    = 64'(address) - 64'(BASE) + 64'(LANE);
  assign in_rng = (64'(address) >= 64'(BASE)) && (off < 64'(DEPTH));
  assign act    = en && in_rng;
  assign idx    = off[IW-1:0];
endmodule

module dout_mem_vec #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 10000,
  parameter int BASE  = 24,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   re,
  input  logic [WIDTH-1:0]       address,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] wd,
  output logic [LANES*WIDTH-1:0] rd,
  output logic                   rd_valid,
  input  logic                   drain_start,
  output logic [WIDTH-1:0]       drain_data,
  output logic                   drain_valid,
  input  logic                   drain_ready,
  output logic                   drain_last,
  output logic                   busy,
  input  logic                   err_clr,
  output logic                   err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  state_t                        state, state_nxt;
  logic [WIDTH-1:0]              mem [DEPTH];
  logic [LANES-1:0]              in_rng, act;
  logic [LANES-1:0][IW-1:0]      idx;
  logic [LANES-1:0][WIDTH-1:0]   wd_v, rd_q;
  logic [IW-1:0]                 ptr;
  logic                          ptr_last, hs, wr_go, rd_go;

  assign wd_v     = wd;
  assign rd       = rd_q;
  assign busy     = (state != IDLE);
  assign wr_go    = we && !busy;
  assign rd_go    = re && !busy;
  assign ptr_last = (ptr == LAST);
  assign hs       = (state == PRESENT) && drain_ready;

  assign drain_valid = (state == PRESENT);
  assign drain_last  = drain_valid && ptr_last;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      dout_mem_vec_lane #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .LANE(g), .IW(IW)
      ) u_lane (
        .address(address),
        .en     (lane_en[g]),
        .in_rng (in_rng[g]),
        .act    (act[g]),
        .idx    (idx[g])
      );
    end
  endgenerate

  // Storage is deliberately not reset; contents survive reset and drains.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr_go && act[i]) mem[idx[i]] <= wd_v[i];
  end

  // Non-blocking update of mem gives read-before-write on overlapping lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go)
        for (int i = 0; i < LANES; i++)
          rd_q[i] <= act[i] ? mem[idx[i]] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drain_start) state_nxt = FETCH;
      FETCH:   state_nxt = PRESENT;
      PRESENT: if (drain_ready) state_nxt = ptr_last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      drain_data <= '0;
    end else begin
      if (state == IDLE && drain_start) ptr <= '0;
      else if (hs && !ptr_last)         ptr <= ptr + 1'b1;
      if (state == FETCH) drain_data <= mem[ptr];
    end
  end

`ifdef DOUT_MEM_ERR_EN
  logic err_set;

  assign err_set = (we || re) && (busy || |(lane_en & ~in_rng));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_dout_mem_vec.sv
// Scoreboard bench for dout_mem_vec: vector read/write, range drops, error flag,
// drain streaming with back-pressure and reset abort.

module tb_dout_mem_vec;
  localparam int WIDTH = 24;
  localparam int DEPTH = 8;
  localparam int BASE  = 24;
  localparam int LANES = 4;
  localparam int VW    = LANES * WIDTH;
`ifdef DOUT_MEM_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic we = 1'b0, re = 1'b0, drain_start = 1'b0, drain_ready = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] address = '0;
  logic [LANES-1:0] lane_en = '0;
  logic [VW-1:0]    wd = '0;
  logic [VW-1:0]    rd;
  logic [WIDTH-1:0] drain_data;
  logic rd_valid, drain_valid, drain_last, busy, err;

  int checks = 0, errors = 0;
  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [VW-1:0]    rd_exp_q [$];
  logic [VW-1:0]    rd_last = '0;

  always #5 clk = ~clk;

  dout_mem_vec #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE(BASE), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .address(address), .lane_en(lane_en),
    .wd(wd), .rd(rd), .rd_valid(rd_valid), .drain_start(drain_start),
    .drain_data(drain_data), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_last(drain_last), .busy(busy), .err_clr(err_clr), .err(err)
  );

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit lane_ok(input logic [WIDTH-1:0] addr, input int i);
    int ix;
    ix = int'(addr) - BASE + i;
    return (int'(addr) >= BASE) && (ix < DEPTH);
  endfunction

  function automatic logic [VW-1:0] model_rd(input logic [WIDTH-1:0] addr, input logic [LANES-1:0] en);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (en[i] && lane_ok(addr, i)) r[i*WIDTH +: WIDTH] = mem_m[int'(addr) - BASE + i];
    return r;
  endfunction

  function automatic bit model_bad(input logic [WIDTH-1:0] addr, input logic [LANES-1:0] en);
    bit b;
    b = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (en[i] && !lane_ok(addr, i)) b = 1'b1;
    return b;
  endfunction

  // One access cycle; expected read data is captured before the model write.
  task automatic access(input bit w, input bit r, input logic [WIDTH-1:0] addr,
                        input logic [LANES-1:0] en, input logic [VW-1:0] data);
    if (r) rd_exp_q.push_back(model_rd(addr, en));
    if (w)
      for (int i = 0; i < LANES; i++)
        if (en[i] && lane_ok(addr, i)) mem_m[int'(addr) - BASE + i] = data[i*WIDTH +: WIDTH];
    we = w; re = r; address = addr; lane_en = en; wd = data;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle_hold_chk();
    @(posedge clk); #1;
    chk("rd_valid_pulse", rd_valid, 1'b0);
    chk("rd_hold", rd, rd_last);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", err, 1'b0);
  endtask

  task automatic start_drain();
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    chk("busy_start", busy, 1'b1);
  endtask

  task automatic drain_collect(input bit toggle, input int k0);
    int k, cyc;
    k = k0; cyc = 0;
    while (k < DEPTH && cyc < 200) begin
      drain_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      if (drain_valid) chk("drain_last", drain_last, k == DEPTH - 1);
      if (drain_valid && drain_ready) begin
        chk("drain_data", drain_data, mem_m[k]);
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drain_ready = 1'b0;
    chk("drain_count", k, DEPTH);
    chk("busy_end", busy, 1'b0);
    chk("valid_end", drain_valid, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (rd_exp_q.size() == 0) chk("rd_unexpected", rd_valid, 1'b0);
      else begin
        rd_last = rd_exp_q.pop_front();
        chk("rd_data", rd, rd_last);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] held;
    int k, cyc;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    #1;
    chk("rst_rd", rd, '0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drain_valid", drain_valid, 1'b0);
    chk("rst_drain_last", drain_last, 1'b0);
    chk("rst_drain_data", drain_data, '0);
    chk("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    access(1, 0, 24, 4'b1111, '0);
    access(1, 0, 28, 4'b1111, '0);

    access(1, 0, 24, 4'b1111, {24'hD4, 24'hC3, 24'hB2, 24'hA1});
    access(0, 1, 25, 4'b1111, '0);
    chk("err_inrange", err, 1'b0);
    idle_hold_chk();

    access(1, 0, 30, 4'b1111, {24'h44, 24'h33, 24'h22, 24'h11});
    chk("err_top_drop", err, ERR_ON);
    clr_err();
    access(0, 1, 30, 4'b0011, '0);
    idle_hold_chk();

    access(1, 0, 10, 4'b1111, {4{24'hEE}});
    chk("err_below", err, ERR_ON);
    err_clr = 1'b1;
    access(1, 0, 22, 4'b1111, {4{24'h77}});
    err_clr = 1'b0;
    chk("err_set_wins", err, ERR_ON);
    clr_err();
    access(0, 1, 24, 4'b1111, '0);
    idle_hold_chk();

    access(1, 1, 24, 4'b0001, {72'h0, 24'h55});
    access(0, 1, 24, 4'b0101, '0);
    idle_hold_chk();

    for (int n = 0; n < 16; n++)
      access(1'($urandom), 1'($urandom), WIDTH'($urandom_range(32, 20)),
             LANES'($urandom), {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)});
    idle_hold_chk();
    clr_err();

    start_drain();
    drain_collect(1'b1, 0);

    start_drain();
    cyc = 0;
    while (!drain_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("stall_reach_present", drain_valid, 1'b1);
    held = drain_data;
    chk("stall_first", held, mem_m[0]);
    for (int n = 0; n < 5; n++) begin
      we = 1'b1; re = 1'b1; address = 24; lane_en = 4'b1111; wd = '1;
      @(negedge clk);
      chk("stall_data", drain_data, held);
      chk("stall_valid", drain_valid, 1'b1);
      @(posedge clk); #1;
    end
    we = 1'b0; re = 1'b0;
    chk("err_busy_access", err, ERR_ON);
    chk("busy_no_rd", rd_valid, 1'b0);
    drain_collect(1'b0, 0);
    clr_err();

    start_drain();
    k = 0; cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (drain_valid) begin
        chk("abort_data", drain_data, mem_m[k]);
        if (k == 3) begin drain_ready = 1'b0; break; end
        drain_ready = 1'b1;
        k++;
      end else drain_ready = 1'b0;
    end
    chk("abort_idx", k, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", drain_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_last", drain_last, 1'b0);
    chk("abort_data_rst", drain_data, '0);
    chk("abort_rd", rd, '0);
    @(posedge clk); #1 rst = 1'b0;
    start_drain();
    drain_collect(1'b1, 0);

    chk("rd_pending", rd_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
